// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with a fixed 34-cycle occupancy.
//
// The unit accepts one operation at a time. It runs 32 iterations: shift-add
// for multiplies, restoring division for divides. Both work on operand
// magnitudes, and the sign is applied to the final value. The result is
// presented for exactly one cycle in DONE.
//
// Ports:
//   clock         - rising-edge clock
//   reset         - synchronous, active-low reset
//   start         - begin an operation (sampled only in IDLE)
//   funct3        - RV32M op select (MUL..REMU)
//   rs1, rs2      - 32-bit operands
//   rdAddressIn   - destination register index
//   busy          - high in RUN and DONE
//   done          - one-cycle result strobe
//   rd            - result, held until the next DONE
//   rdAddress     - destination index, held until the next DONE
//   rdWriteEnable - register file write strobe (suppressed for x0)
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rdAddressIn,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd,
  output logic [4:0]  rdAddress,
  output logic        rdWriteEnable
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] b_q, b_d;          // multiplicand / divisor magnitude
  logic [31:0] hi_q, hi_d;        // product high word / partial remainder
  logic [31:0] lo_q, lo_d;        // multiplier / dividend, becomes low word / quotient
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d;
  logic        neg_q, neg_d;      // negate product or quotient
  logic        rneg_q, rneg_d;    // negate remainder
  logic        dz_q, dz_d;        // divide by zero
  logic [31:0] rd_q, rd_d;
  logic [4:0]  rdAddress_q, rdAddress_d;

  // operand conditioning at acceptance
  logic        a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // one iteration of the datapath
  logic [32:0] sum;
  logic [32:0] shifted;
  logic [31:0] hi_n, lo_n;

  // final result
  logic [63:0] prod;
  logic [31:0] quo, rem, result;

  always_comb begin
    // Divides use signed operands for DIV/REM (funct3[0]=0). Multiplies are
    // signed on rs1 except for MULHU, and signed on rs2 only for MUL/MULH.
    a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg = a_sgn & rs1[31];
    b_neg = b_sgn & rs2[31];
    a_mag = a_neg ? (~rs1 + 32'd1) : rs1;
    b_mag = b_neg ? (~rs2 + 32'd1) : rs2;
  end

  always_comb begin
    sum     = '0;
    shifted = '0;
    hi_n    = hi_q;
    lo_n    = lo_q;
    if (!op_q[2]) begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
      hi_n = sum[32:1];
      lo_n = {sum[0], lo_q[31:1]};
    end else begin
      shifted = {hi_q, lo_q[31]};
      // When the trial succeeds, the true difference is below the divisor,
      // so 32-bit modular subtraction gives the exact remainder.
      if (shifted >= {1'b0, b_q}) begin
        hi_n = shifted[31:0] - b_q;
        lo_n = {lo_q[30:0], 1'b1};
      end else begin
        hi_n = shifted[31:0];
        lo_n = {lo_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod   = neg_q ? (~{hi_n, lo_n} + 64'd1) : {hi_n, lo_n};
    quo    = neg_q ? (~lo_n + 32'd1) : lo_n;
    rem    = rneg_q ? (~hi_n + 32'd1) : hi_n;
    result = '0;
    case (op_q)
      3'b000:                 result = prod[31:0];
      3'b001, 3'b010, 3'b011: result = prod[63:32];
      3'b100, 3'b101:         result = dz_q ? '1 : quo;
      default:                result = dz_q ? rs1_q : rem;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    rd_d        = rd_q;
    rdAddress_d = rdAddress_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          op_d    = funct3;
          rs1_d   = rs1;
          b_d     = b_mag;
          hi_d    = '0;
          lo_d    = a_mag;
          cnt_d   = '0;
          addr_d  = rdAddressIn;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (rs2 == 32'd0);
        end
      end
      S_RUN: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d     = S_DONE;
          rd_d        = result;
          rdAddress_d = addr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rs1_q       <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      rd_q        <= '0;
      rdAddress_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      rd_q        <= rd_d;
      rdAddress_q <= rdAddress_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign rdWriteEnable = (state_q == S_DONE) && (rdAddress_q != 5'd0);
  assign rd            = rd_q;
  assign rdAddress     = rdAddress_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; the datapath SHALL be fixed at 32 bits.
REQ-002 clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset: sampled low at a clock edge resets the block; no asynchronous path.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1, rs2  input  32 each  operands, taken from the register file read ports.
REQ-007 rdAddressIn  input  5  destination register index for the operation.
REQ-008 busy  output  1  high while an operation is in RUN or DONE.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 rd  output  32  result, driven to the register file write port.
REQ-011 rdAddress  output  5  destination index, driven to the register file rdAddress.
REQ-012 rdWriteEnable  output  1  register file write strobe.

Function
REQ-013 States SHALL be IDLE, RUN and DONE.
- IDLE->RUN on an edge with start=1.
- RUN->DONE after 32 iterations.
- DONE->IDLE unconditionally after one cycle.
REQ-014 On the accepting edge (E0), the block SHALL latch funct3, rs1, rs2 and rdAddressIn, and clear the iteration counter to 0; later input changes SHALL NOT affect the result.
REQ-015 Edges E1..E32 SHALL perform one iteration each (shift-add multiply / restoring divide on magnitudes); E32 SHALL enter DONE.
REQ-016 The cycle after E32 is DONE.
- done=1 and rd=final result.
- rdAddress=latched index.
- rdWriteEnable=1 unless the latched index is 0, in which case rdWriteEnable=0 and done=1.
REQ-017 Latency SHALL be fixed for every op and operand value: done is high exactly 33 cycles after the start edge; there is no early termination.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-019 start while busy (including the DONE cycle) SHALL be ignored and not queued.
REQ-020 Multiply ops SHALL form the exact 64-bit product, with operand signedness per op:
- MUL, MULH: signed x signed.
- MULHSU: signed rs1 x unsigned rs2.
- MULHU: unsigned x unsigned.
MUL SHALL return bits 31:0 of the product; the MULH* ops SHALL return bits 63:32.
REQ-021 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-022 Divide by zero (rs2=0):
- DIV/DIVU quotient SHALL be 0xFFFFFFFF.
- REM/REMU SHALL return rs1.
REQ-023 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-024 rd and rdAddress SHALL hold their last values after DONE until the next DONE; done and rdWriteEnable SHALL be 0 outside DONE.

Reset
REQ-025 reset low at any edge SHALL force IDLE and clear busy, done, rdWriteEnable, rd, rdAddress and the counter to 0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no write (rdWriteEnable stays 0).
REQ-027 start sampled in the same cycle as reset low SHALL be ignored.

Verification
REQ-028 MUL rs1=7, rs2=0xFFFFFFFD, rdAddressIn=5 -> after 33 cycles, one cycle of done=1, rdWriteEnable=1, rdAddress=5, rd=0xFFFFFFEB.
REQ-029 High-word ops:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 Signed divide:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
- DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-031 Corner cases:
- DIVU 1234/0 -> 0xFFFFFFFF; REM 1234%0 -> 1234.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-032 Handshake and reset:
- start pulsed in cycles 5 and 33 after an accepted start -> ignored, exactly one done.
- reset low at cycle 10 of RUN -> busy=0 next cycle, no rdWriteEnable pulse ever.
REQ-033 rdAddressIn=0 with MUL 3x4 -> done=1, rdWriteEnable=0, rd=12.
